// File: rtl/fifo_rd_ptr_sync.sv
// rtl/fifo_rd_ptr_sync.sv - single-clock valid/ready FIFO with non-power-of-two pointer wrap
module fifo_rd_ptr_sync #(
  parameter int Width = 8,
  parameter int Depth = 5,
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [Width-1:0]    wr_data_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [Width-1:0]    rd_data_o,
  output logic [CntWidth-1:0] depth_o
);

  if (Depth < 1) begin : g_depth_check
    $error("fifo_rd_ptr_sync: Depth must be at least 1");
  end

  logic [CntWidth-1:0] count_q, count_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]    mem_q [Depth];
  logic                full, empty, push, pop;

  // Status comes only from the registered count, so ready/valid never
  // depend combinationally on the opposite handshake input.
  assign full       = (count_q == CntWidth'(Depth));
  assign empty      = (count_q == '0);
  assign wr_ready_o = ~full;
  assign rd_valid_o = ~empty;
  assign push       = wr_valid_i & ~full;
  assign pop        = rd_ready_i & ~empty;
  assign depth_o    = count_q;

  // Wrap at the last legal entry rather than at the power-of-two boundary.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  // Next-state for pointers and occupancy; a flush wins over any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  if (Depth > 1) begin : g_ptr
    // Pointer registers for multi-entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end
  end else begin : g_ptr_tied
    // A single entry is always slot 0; full/empty come from the count alone.
    assign wr_ptr_q = '0;
    assign rd_ptr_q = '0;
  end

  // Storage is deliberately not reset; a flushed push must not land.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Head of queue, forced to zero while nothing is stored.
  always_comb begin
    rd_data_o = '0;
    if (!empty) rd_data_o = mem_q[rd_ptr_q];
  end

  // Occupancy bound and handshake legality.
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  count_q <= CntWidth'(Depth));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(pop && empty));

endmodule
